ws2812b_pixel_rx: RTL and testbench
===================================

Name: ws2812b_pixel_rx

Overview:
Receive-side counterpart of the WS2812B transmit path: behaves as one WS2812B pixel on the strip.
- Decodes the NZR one-wire stream by measuring high-pulse widths.
- Captures the first 24 bits of each frame as its own GRB word.
- Forwards all later bits on dataOut to the next pixel.
- Detects the >280 us low reset/latch gap.
Used as a bench/loopback checker for the LED driver and as a chainable pixel model.

Parameters:
- BIT_THRESH, 30: high-time in clk cycles at or above which a bit decodes as 1 (0.6 us at 50 MHz).
- MAX_HIGH, 100: high-time in cycles at which the pulse is declared illegal (2 us).
- RESET_CYCLES, 14000: continuous low cycles that end a frame (280 us at 50 MHz).

Ports:
- clk, input, 1: system clock; all logic on rising edge.
- reset, input, 1: asynchronous, active-low reset; clears all state immediately.
- dataIn, input, 1: NZR serial input from upstream; asynchronous to clk.
- dataOut, output, 1: forwarded NZR stream to the downstream pixel.
- grb, output, 24: last captured colour {G[7:0],R[7:0],B[7:0]}, MSB first as received.
- grbValid, output, 1: one-cycle pulse when grb is updated.
- frameDone, output, 1: one-cycle pulse when a reset gap is recognised.
- protoErr, output, 1: one-cycle pulse on a protocol violation.

Behaviour:
- Reset values: dataOut=0, grb=24'h0, grbValid=0, frameDone=0, protoErr=0, state=IDLE, all counters 0, passEn=0.

Input conditioning:
- dataIn passes through a 2-flop synchroniser giving din_s.
- Edges are detected against a registered copy of din_s.
- Pin-to-decision latency is 3 clk cycles.

Counters:
- highCnt saturates at MAX_HIGH.
- lowCnt is $clog2(RESET_CYCLES+1) bits wide and saturates at RESET_CYCLES.
- bitIdx counts 0..24 and saturates at 24.

FSM states: IDLE, HIGH, LOW, ERR.
- IDLE: lowCnt counts while the line is low. Rising edge -> HIGH, highCnt=1.
- HIGH: highCnt increments each cycle.
  - Falling edge with highCnt < MAX_HIGH -> LOW, lowCnt=1. Decoded bit = (highCnt >= BIT_THRESH).
  - highCnt reaching MAX_HIGH -> ERR, protoErr pulses.
- LOW: lowCnt increments.
  - Rising edge -> HIGH.
  - lowCnt reaching RESET_CYCLES -> end of frame (see Frame end), then IDLE.
- ERR: nothing is decoded or forwarded; passEn=0. A full RESET_CYCLES low gap -> IDLE, with frameDone pulsed and bitIdx=0. grb is not updated.

Bit capture:
- While bitIdx < 24, each decoded bit shifts into shreg at the LSB (first bit ends at shreg[23]) and bitIdx increments.
- When bitIdx goes from 23 to 24:
  - grb <= completed word.
  - grbValid pulses in the cycle after the decode.
  - passEn sets.

Forwarding:
- dataOut is registered: dataOut <= din_s & passEn & (state != ERR).
- passEn sets after the 24th bit's falling edge, so bit 25 is forwarded whole.
- Forwarded pulse widths are preserved exactly; the pin-to-dataOut delay is 3 cycles.

Frame end:
- frameDone pulses; bitIdx=0; passEn=0; shreg cleared.
- If 0 < bitIdx < 24 at frame end (short frame), protoErr also pulses in the same cycle and grb holds its old value.
- A frame of exactly 0 bits (continued idle) does not re-pulse frameDone. It pulses once per gap, re-armed by the next rising edge.

Simultaneous and edge cases:
- Reset assertion at any point, including mid-bit, clears all state asynchronously.
- After release, the block starts in IDLE and accepts the first rising edge as bit 0.
- Low gaps shorter than RESET_CYCLES between bits are legal at any length.
- A line held high through reset release is treated as a pulse starting at release and is subject to the MAX_HIGH check.

Test Plan:
1. At 50 MHz, send 24 bits of 0xFF0000 (T1H=40, T0H=20, period 62 cycles), then 14000 low -> grb=24'hFF0000; exactly one grbValid pulse 3 cycles after the 24th pin falling edge; one frameDone; dataOut stays 0.
2. Send 48 bits: 0x123456 then 0xABCDEF -> grb=24'h123456; dataOut reproduces the second 24 pulses with identical widths delayed 3 cycles; frameDone after 14000 low cycles.
3. Threshold sweep: high of 29 cycles decodes as 0, 30 decodes as 1; 24 bits alternating 29/30 -> grb=24'h555555.
4. High pulse of 100 cycles on bit 5 -> protoErr pulse; no grbValid; dataOut 0; frameDone after gap; the next frame of 0x00FF00 captures correctly.
5. Only 10 bits, then 14000 low -> protoErr and frameDone in the same cycle; grb keeps its previous value.
6. Assert reset low mid-way through a forwarded high pulse -> dataOut, grbValid and protoErr drop to 0 and grb becomes 24'h0 without waiting for a clk edge; after release a fresh 24-bit frame decodes correctly.

Source files
------------

// File: rtl/ws2812b_pixel_rx.sv
// ws2812b_pixel_rx: one WS2812B pixel - decodes NZR, captures its GRB word, forwards the rest
module ws2812b_pixel_rx #(
    parameter int BIT_THRESH   = 30,
    parameter int MAX_HIGH     = 100,
    parameter int RESET_CYCLES = 14000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        dataIn,
    output logic        dataOut,
    output logic [23:0] grb,
    output logic        grbValid,
    output logic        frameDone,
    output logic        protoErr
);
    localparam int HW = $clog2(MAX_HIGH + 1);
    localparam int LW = $clog2(RESET_CYCLES + 1);
    localparam logic [1:0] IDLE = 2'd0, HIGH = 2'd1, LOW = 2'd2, ERR = 2'd3;
    localparam logic [HW-1:0] H_MAX  = HW'(MAX_HIGH);
    localparam logic [HW-1:0] H_LAST = HW'(MAX_HIGH - 1);
    localparam logic [HW-1:0] H_TH   = HW'(BIT_THRESH);
    localparam logic [LW-1:0] L_MAX  = LW'(RESET_CYCLES);
    localparam logic [LW-1:0] L_LAST = LW'(RESET_CYCLES - 1);

    logic          s1, din_s, din_d, pass_en;
    logic [1:0]    state;
    logic [HW-1:0] high_cnt;
    logic [LW-1:0] low_cnt;
    logic [4:0]    bit_idx;
    logic [23:0]   shreg;
    logic          rise, fall, bit_val;

    assign rise    = din_s & ~din_d;
    assign fall    = ~din_s & din_d;
    assign bit_val = high_cnt >= H_TH;

    // two-flop synchroniser plus a delayed copy for edge detection
    always_ff @(posedge clk or negedge reset)
        if (!reset) {s1, din_s, din_d} <= 3'b000;
        else {s1, din_s, din_d} <= {dataIn, s1, din_s};

    // pulse-width FSM, bit capture, forwarding and frame bookkeeping
    always_ff @(posedge clk or negedge reset)
        if (!reset) begin
            state     <= IDLE;
            high_cnt  <= '0;
            low_cnt   <= '0;
            bit_idx   <= '0;
            shreg     <= '0;
            pass_en   <= 1'b0;
            dataOut   <= 1'b0;
            grb       <= '0;
            grbValid  <= 1'b0;
            frameDone <= 1'b0;
            protoErr  <= 1'b0;
        end else begin
            grbValid  <= 1'b0;
            frameDone <= 1'b0;
            protoErr  <= 1'b0;
            dataOut   <= din_s & pass_en & (state != ERR);
            case (state)
                IDLE:
                    if (rise) begin
                        state    <= HIGH;
                        high_cnt <= HW'(1);
                    end else if (low_cnt != L_MAX) low_cnt <= low_cnt + 1'b1;
                HIGH:
                    if (fall) begin
                        state   <= LOW;
                        low_cnt <= LW'(1);
                        if (bit_idx < 5'd24) begin
                            shreg   <= {shreg[22:0], bit_val};
                            bit_idx <= bit_idx + 5'd1;
                            if (bit_idx == 5'd23) begin
                                grb      <= {shreg[22:0], bit_val};
                                grbValid <= 1'b1;
                                pass_en  <= 1'b1;
                            end
                        end
                    end else if (high_cnt == H_LAST) begin
                        state    <= ERR;
                        high_cnt <= H_MAX;
                        low_cnt  <= '0;
                        protoErr <= 1'b1;
                        pass_en  <= 1'b0;
                    end else high_cnt <= high_cnt + 1'b1;
                LOW:
                    if (rise) begin
                        state    <= HIGH;
                        high_cnt <= HW'(1);
                    end else if (low_cnt == L_LAST) begin
                        state     <= IDLE;
                        low_cnt   <= L_MAX;
                        frameDone <= 1'b1;
                        protoErr  <= (bit_idx != 5'd0) && (bit_idx < 5'd24);
                        bit_idx   <= '0;
                        pass_en   <= 1'b0;
                        shreg     <= '0;
                    end else low_cnt <= low_cnt + 1'b1;
                default:
                    if (din_s) low_cnt <= '0;
                    else if (low_cnt == L_LAST) begin
                        state     <= IDLE;
                        low_cnt   <= L_MAX;
                        frameDone <= 1'b1;
                        bit_idx   <= '0;
                        pass_en   <= 1'b0;
                        shreg     <= '0;
                    end else low_cnt <= low_cnt + 1'b1;
            endcase
        end
endmodule

// File: tb/tb_ws2812b_pixel_rx.sv
// tb_ws2812b_pixel_rx: randomized NZR frames checked against a pulse-list reference model
module tb_ws2812b_pixel_rx;
    localparam int RC = 600, MH = 100, TH = 30;

    logic        clk = 1'b0, reset = 1'b0, dataIn = 1'b0;
    logic        dataOut, grbValid, frameDone, protoErr;
    logic [23:0] grb;

    ws2812b_pixel_rx #(.BIT_THRESH(TH), .MAX_HIGH(MH), .RESET_CYCLES(RC)) dut (
        .clk(clk), .reset(reset), .dataIn(dataIn), .dataOut(dataOut),
        .grb(grb), .grbValid(grbValid), .frameDone(frameDone), .protoErr(protoErr)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int   gv_n = 0, fd_n = 0, pe_n = 0, gv_at = 0, fd_at = 0, pe_at = 0, do_rise = 0;
    logic do_d = 1'b0;
    int   fw_w[$], fw_r[$];

    // output monitor: event counts, event cycles, forwarded pulse widths
    always @(negedge clk) begin
        if (grbValid) begin gv_n++; gv_at = cyc; end
        if (frameDone) begin fd_n++; fd_at = cyc; end
        if (protoErr) begin pe_n++; pe_at = cyc; end
        if (dataOut && !do_d) do_rise = cyc;
        if (!dataOut && do_d) begin fw_w.push_back(cyc - do_rise); fw_r.push_back(do_rise); end
        do_d = dataOut;
    end

    int total = 0, bad = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    int          hs[64];
    int          nb;
    logic [23:0] last_grb = '0;

    task automatic drive(input logic v, input int n);
        dataIn = v;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic gen(input logic [23:0] c, input int n, input bit fixed);
        logic b;
        nb = n;
        for (int i = 0; i < n; i++) begin
            b = (i < 24) ? c[23-i] : 1'($urandom_range(0, 1));
            hs[i] = fixed ? (b ? 40 : 20) : (b ? $urandom_range(TH, MH - 1) : $urandom_range(3, TH - 1));
        end
    endtask

    task automatic run_frame();
        int k, err, egv, epe, f24, rp, g0, f0, p0, rc, n;
        logic [23:0] w;
        int er[$], ew[$];
        k = 0; err = 0; egv = 0; epe = 0; f24 = 0; w = '0;
        g0 = gv_n; f0 = fd_n; p0 = pe_n; rp = fw_w.size();
        for (int i = 0; i < nb; i++) begin
            rc = cyc;
            drive(1'b1, hs[i]);
            if (!err && hs[i] >= MH) begin
                err = 1;
                epe++;
            end else if (!err) begin
                if (k < 24) begin
                    w = {w[22:0], hs[i] >= TH};
                    k++;
                    if (k == 24) begin egv = 1; f24 = cyc; end
                end else begin
                    er.push_back(rc + 3);
                    ew.push_back(hs[i]);
                end
            end
            drive(1'b0, (i == nb - 1) ? RC + 20 : $urandom_range(5, 60));
        end
        if (!err && k > 0 && k < 24) epe++;
        if (!err && k == 24) last_grb = w;
        chk("frameDone", fd_n - f0, 1);
        chk("grbValid", gv_n - g0, egv);
        chk("protoErr", pe_n - p0, epe);
        chk("grb", grb, last_grb);
        if (egv != 0) chk("gv_lat", gv_at - f24, 3);
        if (!err && k > 0 && k < 24) chk("pe_fd_same", pe_at, fd_at);
        chk("fwd_n", fw_w.size() - rp, ew.size());
        n = (fw_w.size() - rp < ew.size()) ? fw_w.size() - rp : ew.size();
        for (int j = 0; j < n; j++) begin
            chk("fwd_w", fw_w[rp+j], ew[j]);
            chk("fwd_at", fw_r[rp+j], er[j]);
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL timeout total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

    initial begin
        repeat (3) @(posedge clk);
        #1;
        chk("rst_dataOut", dataOut, 0);
        chk("rst_grb", grb, 0);
        chk("rst_grbValid", grbValid, 0);
        chk("rst_frameDone", frameDone, 0);
        chk("rst_protoErr", protoErr, 0);
        reset = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        gen(24'hFF0000, 24, 1'b1);
        run_frame();
        chk("ff0000", grb, 24'hFF0000);
        gen(24'h123456, 48, 1'b0);
        for (int i = 24; i < 48; i++) hs[i] = (24'hABCDEF >> (47 - i)) & 1 ? 40 : 20;
        run_frame();
        chk("123456", grb, 24'h123456);
        nb = 24;
        for (int i = 0; i < 24; i++) hs[i] = (i % 2) ? 30 : 29;
        run_frame();
        chk("thresh", grb, 24'h555555);
        gen(24'($urandom), 24, 1'b0);
        hs[5] = MH;
        run_frame();
        gen(24'h00FF00, 24, 1'b0);
        run_frame();
        chk("00ff00", grb, 24'h00FF00);
        gen(24'($urandom), 10, 1'b0);
        run_frame();
        chk("short_keep", grb, 24'h00FF00);
        repeat (8) begin
            gen(24'($urandom), $urandom_range(1, 36), 1'b0);
            if ($urandom_range(0, 3) == 0) hs[$urandom_range(0, (nb > 24 ? 24 : nb) - 1)] = $urandom_range(MH, MH + 20);
            run_frame();
        end
        gen(24'hA5C3E1, 26, 1'b0);
        for (int i = 0; i < 25; i++) begin drive(1'b1, hs[i]); drive(1'b0, 20); end
        dataIn = 1'b1;
        repeat (10) @(posedge clk);
        #2;
        chk("fwd_hi", dataOut, 1);
        chk("pre_rst_grb", grb, 24'hA5C3E1);
        reset = 1'b0;
        #1;
        chk("arst_dataOut", dataOut, 0);
        chk("arst_grb", grb, 0);
        chk("arst_grbValid", grbValid, 0);
        chk("arst_protoErr", protoErr, 0);
        dataIn = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        last_grb = '0;
        gen(24'($urandom), 24, 1'b0);
        run_frame();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
